// File: rtl/rr_arbiter16_pkg.sv
// Shared widths and state codes for the 16-way round-robin arbiter.
// No logic here: constants and the FSM state type only.
// Imported by the arbiter top and its grant decoder.
package rr_arbiter16_pkg;

  localparam int N_REQ  = 16;
  localparam int SEL_W  = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter16_demux16.sv
// Purpose: 1-to-16 demux, routes in_i onto the output bit selected by sel_i.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs directly.
module demux16
  import rr_arbiter16_pkg::*;
(
  input  logic             in_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_REQ-1:0] out_o
);

  // Only the selected bit can carry in_i, so the output is one-hot or zero.
  always_comb begin
    out_o        = '0;
    out_o[sel_i] = in_i;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Purpose: round-robin arbiter granting one of 16 level requesters, with an optional hold limit.
// Latency: req sampled at an edge appears on the registered grant one cycle later; no comb path.
// Backpressure: a requester keeps its grant while req stays high, up to MAX_HOLD cycles, then one idle gap.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_id,
  output logic [N_REQ-1:0] grant
);

  // A zero MAX_HOLD disables the timeout; the last-cycle count is only used when enabled.
  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              state_q, state_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic [SEL_W-1:0]    gnt_id_q, gnt_id_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                rel_now;

  // First set request at or after last+1, wrapping; the final step lands on last itself.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] last);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + SEL_W'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Release on req drop or on the final permitted cycle of the tenure; both together are one release.
  assign rel_now = !req[gnt_id_q] || (HOLD_EN && (hold_cnt_q == HOLD_LAST));

  // Next-state and next-output logic; other req bits are ignored while a grant is held.
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d     = ST_GRANT;
          gnt_valid_d = 1'b1;
          gnt_id_d    = rr_pick(req, last_q);
          hold_cnt_d  = '0;
        end
      end
      ST_GRANT: begin
        if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        if (rel_now) begin
          // gnt_id keeps its value; the preempted index becomes lowest priority.
          state_d     = ST_IDLE;
          gnt_valid_d = 1'b0;
          last_d      = gnt_id_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; last resets to 15 so the first search starts at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_q      <= '1;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

  demux16 u_demux (
    .in_i  (gnt_valid_q),
    .sel_i (gnt_id_q),
    .out_o (grant)
  );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: two instances (MAX_HOLD=8 and MAX_HOLD=1) share clock, reset and req.
// A tenure-level model predicts every output each cycle; directed sequences add literal expectations.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;

  logic        v8, v1;
  logic [3:0]  id8, id1;
  logic [15:0] g8, g1;

  int n_pass  = 0;
  int n_total = 0;

  // model state per instance: owner (-1 none), visible id, last winner, cycles held
  int mh   [2] = '{8, 1};
  int own  [2];
  int gid  [2];
  int lst  [2];
  int len  [2];

  always #5 clk = ~clk;

  rr_arbiter16 #(.MAX_HOLD(8)) u8 (
    .clk(clk), .reset(reset), .req(req),
    .gnt_valid(v8), .gnt_id(id8), .grant(g8)
  );

  rr_arbiter16 #(.MAX_HOLD(1)) u1 (
    .clk(clk), .reset(reset), .req(req),
    .gnt_valid(v1), .gnt_id(id1), .grant(g1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: idle picks first requester after the last winner; a tenure ends on req drop or after mh cycles.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        own[m] = -1; gid[m] = 0; lst[m] = 15; len[m] = 0;
      end else if (own[m] < 0) begin
        if (req != 16'h0) begin
          for (int k = 16; k >= 1; k--)
            if (req[(lst[m] + k) % 16]) own[m] = (lst[m] + k) % 16;
          gid[m] = own[m];
          len[m] = 1;
        end
      end else if (!req[own[m]] || (mh[m] != 0 && len[m] >= mh[m])) begin
        lst[m] = own[m];
        own[m] = -1;
      end else begin
        len[m]++;
      end
    end
  end

  task automatic cmp(input int m, input logic v, input logic [3:0] id, input logic [15:0] g);
    logic [15:0] eg;
    eg = (own[m] >= 0) ? (16'h1 << own[m]) : 16'h0;
    check($sformatf("m%0d_vld", m), {31'b0, v}, (own[m] >= 0) ? 32'd1 : 32'd0);
    check($sformatf("m%0d_id", m), {28'b0, id}, gid[m]);
    check($sformatf("m%0d_grant", m), {16'b0, g}, {16'b0, eg});
    check($sformatf("m%0d_onehot0", m), {31'b0, $onehot0(g)}, 32'd1);
  endtask

  // Every falling edge: both instances against the model.
  always @(negedge clk) begin
    cmp(0, v8, id8, g8);
    cmp(1, v1, id1, g1);
  end

  task automatic pulse_reset();
    reset = 1'b1;
    req   = 16'h0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req   = 16'hFFFF;

    // reset held two cycles with all requests high
    repeat (2) begin
      @(negedge clk);
      check("rst_vld", {31'b0, v8}, 32'd0);
      check("rst_grant", {16'b0, g8}, 32'd0);
      check("rst_id", {28'b0, id8}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("first_id", {28'b0, id8}, 32'd0);
    check("first_grant", {16'b0, g8}, 32'h0001);
    check("first_vld", {31'b0, v8}, 32'd1);

    // single requester 5: 8 granted cycles, one gap, regrant, twice over
    pulse_reset();
    req = 16'h0020;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        check("single_id", {28'b0, id8}, 32'd5);
        check("single_grant", {16'b0, g8}, 32'h0020);
      end
      @(negedge clk);
      check("single_gap", {31'b0, v8}, 32'd0);
      check("single_gap_grant", {16'b0, g8}, 32'h0);
    end
    @(negedge clk);
    check("single_regrant", {16'b0, g8}, 32'h0020);

    // full rotation on the MAX_HOLD=1 instance
    pulse_reset();
    req = 16'hFFFF;
    for (int k = 0; k <= 16; k++) begin
      logic [15:0] one;
      one = 16'h1 << (k % 16);
      @(negedge clk);
      check("rot_id", {28'b0, id1}, k % 16);
      check("rot_grant", {16'b0, g1}, {16'b0, one});
      @(negedge clk);
      check("rot_gap", {31'b0, v1}, 32'd0);
    end

    // early release: 2 drops after 3 granted cycles, then 8 wins
    pulse_reset();
    req = 16'h0104;
    repeat (3) begin
      @(negedge clk);
      check("early_id2", {28'b0, id8}, 32'd2);
    end
    req = 16'h0100;
    @(negedge clk);
    check("early_gap", {31'b0, v8}, 32'd0);
    check("early_gap_id", {28'b0, id8}, 32'd2);
    @(negedge clk);
    check("early_id8", {28'b0, id8}, 32'd8);
    check("early_grant8", {16'b0, g8}, 32'h0100);

    // wrap-around: last=14, then 14 and 0 request; 0 must win
    pulse_reset();
    req = 16'h4000;
    @(negedge clk);
    check("wrap_id14", {28'b0, id8}, 32'd14);
    req = 16'h0;
    @(negedge clk);
    check("wrap_gap", {31'b0, v8}, 32'd0);
    req = 16'h4001;
    @(negedge clk);
    check("wrap_id", {28'b0, id8}, 32'd0);
    check("wrap_grant", {16'b0, g8}, 32'h0001);

    // reset in the middle of a grant to 9
    pulse_reset();
    req = 16'h0200;
    @(negedge clk);
    @(negedge clk);
    check("mid_id9", {28'b0, id8}, 32'd9);
    reset = 1'b1;
    req   = 16'h0201;
    @(negedge clk);
    check("mid_vld", {31'b0, v8}, 32'd0);
    check("mid_grant", {16'b0, g8}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_after_id", {28'b0, id8}, 32'd0);
    check("mid_after_grant", {16'b0, g8}, 32'h0001);

    // let the model run a few more cycles on a busy pattern
    req = 16'hA5A5;
    repeat (40) @(negedge clk);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
